// File: rtl/ahb_dbg_arbiter.sv
// Two-master AHB arbiter and address/data mux sharing one slave bus between the core (C)
// and the debugger (D). Debugger has priority, bounded by a fairness counter.
module ahb_dbg_arbiter #(
    parameter int unsigned DBG_MAX_CONSEC = 8,
    parameter bit          DEFAULT_MASTER = 1'b0
) (
    input  logic        clk,
    input  logic        n_Rst,
    input  logic        HBUSREQ_C,
    input  logic        HBUSREQ_D,
    output logic        HGRANT_C,
    output logic        HGRANT_D,
    input  logic [1:0]  HTRANS_C,
    input  logic [1:0]  HTRANS_D,
    input  logic [31:0] HADDR_C,
    input  logic [31:0] HADDR_D,
    input  logic        HWRITE_C,
    input  logic        HWRITE_D,
    input  logic [2:0]  HSIZE_C,
    input  logic [2:0]  HSIZE_D,
    input  logic [2:0]  HBURST_C,
    input  logic [2:0]  HBURST_D,
    input  logic [31:0] HWDATA_C,
    input  logic [31:0] HWDATA_D,
    input  logic        HREADY,
    output logic [1:0]  HTRANS,
    output logic [31:0] HADDR,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [31:0] HWDATA,
    output logic        HMASTER,
    output logic        HMASTER_D
);

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransNonseq = 2'b10;
    localparam logic [1:0] TransSeq    = 2'b11;
    localparam logic [7:0] MaxConsec   = 8'(DBG_MAX_CONSEC);

    logic       grant_d_q, grant_d_d;
    logic       addr_owner_q, addr_owner_d;
    logic       data_owner_q, data_owner_d;
    logic [3:0] beat_cnt_q, beat_cnt_d;
    logic [7:0] consec_cnt_q, consec_cnt_d;
    logic       accept, nonseq_acc, seq_acc, rearb, fair_trip;

    assign HTRANS    = addr_owner_q ? HTRANS_D : HTRANS_C;
    assign HADDR     = addr_owner_q ? HADDR_D  : HADDR_C;
    assign HWRITE    = addr_owner_q ? HWRITE_D : HWRITE_C;
    assign HSIZE     = addr_owner_q ? HSIZE_D  : HSIZE_C;
    assign HBURST    = addr_owner_q ? HBURST_D : HBURST_C;
    assign HWDATA    = data_owner_q ? HWDATA_D : HWDATA_C;
    assign HMASTER   = addr_owner_q;
    assign HMASTER_D = data_owner_q;
    assign HGRANT_D  = grant_d_q;
    assign HGRANT_C  = ~grant_d_q;

    assign accept     = HREADY && (HTRANS != TransIdle);
    assign nonseq_acc = accept && (HTRANS == TransNonseq);
    assign seq_acc    = accept && (HTRANS == TransSeq);

    // Remaining beats after the one just accepted; fixed-length bursts are never broken.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (nonseq_acc) begin
            case (HBURST)
                3'b010, 3'b011: beat_cnt_d = 4'd3;
                3'b100, 3'b101: beat_cnt_d = 4'd7;
                3'b110, 3'b111: beat_cnt_d = 4'd15;
                default:        beat_cnt_d = 4'd0;
            endcase
        end else if (seq_acc && (beat_cnt_q != 4'd0)) begin
            beat_cnt_d = beat_cnt_q - 4'd1;
        end
    end

    assign rearb = (beat_cnt_d <= 4'd1);

    always_comb begin
        consec_cnt_d = consec_cnt_q;
        if (!HBUSREQ_C) begin
            consec_cnt_d = 8'd0;
        end else if (nonseq_acc) begin
            if (!addr_owner_q) begin
                consec_cnt_d = 8'd0;
            end else if (consec_cnt_q < MaxConsec) begin
                consec_cnt_d = consec_cnt_q + 8'd1;
            end
        end
    end

    // The +1 accounts for the debugger transfer already committed to the next address
    // phase by the grant it currently holds, so exactly DBG_MAX_CONSEC transfers run.
    assign fair_trip = grant_d_q && HBUSREQ_C && HBUSREQ_D &&
                       (({1'b0, consec_cnt_d} + 9'd1) >= {1'b0, MaxConsec});

    always_comb begin
        grant_d_d = grant_d_q;
        if (rearb) begin
            if (fair_trip) begin
                grant_d_d = 1'b0;
            end else if (HBUSREQ_D) begin
                grant_d_d = 1'b1;
            end else if (HBUSREQ_C) begin
                grant_d_d = 1'b0;
            end else begin
                grant_d_d = DEFAULT_MASTER;
            end
        end
    end

    // Ownership only advances on a ready edge, so wait states freeze the pipeline.
    always_comb begin
        addr_owner_d = addr_owner_q;
        data_owner_d = data_owner_q;
        if (HREADY) begin
            addr_owner_d = grant_d_q;
            data_owner_d = addr_owner_q;
        end
    end

    always_ff @(posedge clk or negedge n_Rst) begin
        if (!n_Rst) begin
            grant_d_q    <= DEFAULT_MASTER;
            addr_owner_q <= DEFAULT_MASTER;
            data_owner_q <= DEFAULT_MASTER;
            beat_cnt_q   <= 4'd0;
            consec_cnt_q <= 8'd0;
        end else begin
            grant_d_q    <= grant_d_d;
            addr_owner_q <= addr_owner_d;
            data_owner_q <= data_owner_d;
            beat_cnt_q   <= beat_cnt_d;
            consec_cnt_q <= consec_cnt_d;
        end
    end

endmodule
